// File: rtl/parallel_serializer.sv
// parallel_serializer: valid/ready parallel word in, MSB-first serial frame out with a per-bit strobe.
// Define SERIALIZER_GAP_EN to insert GAP_CYCLES idle cycles after every frame.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no frame on the wire; loads the holding register when full
// ST_SHIFT | frame shifting out, each bit held CLKS_PER_BIT cycles
// ST_GAP   | post-frame idle gap (only with SERIALIZER_GAP_EN)
module parallel_serializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic                  i_data_valid,
    output logic                  o_data_ready,
    output logic                  o_serial_out,
    output logic                  o_enable,
    output logic                  o_start,
    output logic                  o_busy
);

    if (DATA_WIDTH < 2) begin : g_chk_width
        $error("parallel_serializer: DATA_WIDTH must be >= 2");
    end
    if (CLKS_PER_BIT < 1) begin : g_chk_cpb
        $error("parallel_serializer: CLKS_PER_BIT must be >= 1");
    end
    if (GAP_CYCLES < 0) begin : g_chk_gap
        $error("parallel_serializer: GAP_CYCLES must be >= 0");
    end

    localparam int PHASE_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(DATA_WIDTH - 1);

`ifdef SERIALIZER_GAP_EN
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam bit GAP_ON = (GAP_CYCLES > 0);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    logic [GAP_W-1:0] r_gap_left;
    logic [GAP_W-1:0] w_gap_left_nxt;
`else
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;
`endif

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH-1:0] w_hold_nxt;
    logic                  r_hold_full;
    logic                  w_hold_full_nxt;
    logic [PHASE_W-1:0]    r_phase_left;
    logic [PHASE_W-1:0]    w_phase_left_nxt;
    logic [BIT_W-1:0]      r_bits_left;
    logic [BIT_W-1:0]      w_bits_left_nxt;
    logic                  w_boundary;
    logic                  w_in_shift;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_hold       <= '0;
            r_hold_full  <= 1'b0;
            r_phase_left <= '0;
            r_bits_left  <= '0;
`ifdef SERIALIZER_GAP_EN
            r_gap_left   <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_hold       <= w_hold_nxt;
            r_hold_full  <= w_hold_full_nxt;
            r_phase_left <= w_phase_left_nxt;
            r_bits_left  <= w_bits_left_nxt;
`ifdef SERIALIZER_GAP_EN
            r_gap_left   <= w_gap_left_nxt;
`endif
        end
    end

    // Phase and bit counters run down; a bit starts when phase is reloaded to PHASE_LAST.
    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_hold_nxt       = r_hold;
        w_hold_full_nxt  = r_hold_full;
        w_phase_left_nxt = r_phase_left;
        w_bits_left_nxt  = r_bits_left;
`ifdef SERIALIZER_GAP_EN
        w_gap_left_nxt   = r_gap_left;
`endif
        w_boundary       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_boundary = 1'b1;
            end
            ST_SHIFT: begin
                if (r_phase_left != '0) begin
                    w_phase_left_nxt = r_phase_left - PHASE_W'(1);
                end else if (r_bits_left != '0) begin
                    w_shift_nxt      = {r_shift[DATA_WIDTH-2:0], 1'b0};
                    w_bits_left_nxt  = r_bits_left - BIT_W'(1);
                    w_phase_left_nxt = PHASE_LAST;
                end else begin
`ifdef SERIALIZER_GAP_EN
                    if (GAP_ON) begin
                        w_state_nxt    = ST_GAP;
                        w_gap_left_nxt = GAP_LAST;
                    end else begin
                        w_boundary = 1'b1;
                    end
`else
                    w_boundary = 1'b1;
`endif
                end
            end
`ifdef SERIALIZER_GAP_EN
            ST_GAP: begin
                if (r_gap_left != '0) begin
                    w_gap_left_nxt = r_gap_left - GAP_W'(1);
                end else begin
                    w_boundary = 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Frame boundary: reload straight from the holding register for zero-idle frames.
        if (w_boundary) begin
            if (r_hold_full) begin
                w_state_nxt      = ST_SHIFT;
                w_shift_nxt      = r_hold;
                w_hold_full_nxt  = 1'b0;
                w_phase_left_nxt = PHASE_LAST;
                w_bits_left_nxt  = BIT_LAST;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end

        if (i_data_valid && !r_hold_full) begin
            w_hold_nxt      = i_data_in;
            w_hold_full_nxt = 1'b1;
        end
    end

    assign w_in_shift   = (r_state == ST_SHIFT);
    assign o_data_ready = !r_hold_full;
    assign o_enable     = w_in_shift && (r_phase_left == PHASE_LAST);
    assign o_start      = o_enable && (r_bits_left == BIT_LAST);
    assign o_serial_out = w_in_shift && r_shift[DATA_WIDTH-1];
    assign o_busy       = (r_state != ST_IDLE) || r_hold_full;

endmodule

// File: tb/tb_parallel_serializer.sv
// Bench for parallel_serializer: a CPB=1 and a CPB=3 instance, frames recovered by a
// behavioural deserializer and compared against an arithmetic timing/data model.
`timescale 1ns/1ps
module tb_parallel_serializer;

    localparam int W = 8;
`ifdef SERIALIZER_GAP_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a_data = '0;
    logic       a_valid = 1'b0;
    logic       a_ready, a_ser, a_en, a_start, a_busy;
    logic [7:0] b_data = '0;
    logic       b_valid = 1'b0;
    logic       b_ready, b_ser, b_en, b_start, b_busy;

    int checks = 0;
    int errors = 0;

    parallel_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .GAP_CYCLES(2)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_data_in(a_data), .i_data_valid(a_valid),
        .o_data_ready(a_ready), .o_serial_out(a_ser), .o_enable(a_en),
        .o_start(a_start), .o_busy(a_busy)
    );

    parallel_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(3), .GAP_CYCLES(2)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_data_in(b_data), .i_data_valid(b_valid),
        .o_data_ready(b_ready), .o_serial_out(b_ser), .o_enable(b_en),
        .o_start(b_start), .o_busy(b_busy)
    );

    always #5 clk = ~clk;

    // Behavioural deserializer on DUT A: collects completed frames and handshake cycles.
    typedef struct {
        int         st;
        int         last;
        logic [7:0] w;
    } frame_t;

    frame_t     frames[$];
    int         acc_q[$];
    int         cyc = 0;
    int         nbits = 0;
    int         fst = 0;
    logic [7:0] cur = '0;
    frame_t     fr;

    always @(posedge clk) begin
        if (!rst_n) begin
            nbits = 0;
        end else begin
            if (a_en) begin
                if (a_start) begin
                    nbits = 0;
                    fst   = cyc;
                end
                cur   = {cur[6:0], a_ser};
                nbits = nbits + 1;
                if (nbits == W) begin
                    fr.st   = fst;
                    fr.last = cyc;
                    fr.w    = cur;
                    frames.push_back(fr);
                    nbits = 0;
                end
            end
            if (a_valid && a_ready) acc_q.push_back(cyc);
        end
        cyc = cyc + 1;
    end

    // Reference model inputs (what the bench offered and when) and predictions.
    int         m_vcyc[$];
    logic [7:0] m_word[$];
    int         m_acc[$];
    int         m_st[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        frames.delete();
        acc_q.delete();
        m_vcyc.delete();
        m_word.delete();
        m_acc.delete();
        m_st.delete();
    endtask

    // A word is taken once the previous one has started; it starts two cycles after
    // acceptance or one frame (plus gap) after its predecessor, whichever is later.
    task automatic model_run();
        int a;
        int s;
        m_acc.delete();
        m_st.delete();
        foreach (m_vcyc[i]) begin
            if (i == 0) begin
                a = m_vcyc[i];
                s = a + 2;
            end else begin
                a = (m_vcyc[i] > m_st[i-1]) ? m_vcyc[i] : m_st[i-1];
                s = (a + 2 > m_st[i-1] + W + GAP) ? a + 2 : m_st[i-1] + W + GAP;
            end
            m_acc.push_back(a);
            m_st.push_back(s);
        end
    endtask

    task automatic send_a(input logic [7:0] d, input bit keep_valid, output bit ok);
        logic rdy;
        ok = 1'b0;
        a_data  = d;
        a_valid = 1'b1;
        m_vcyc.push_back(cyc);
        m_word.push_back(d);
        for (int i = 0; i < 200; i++) begin
            rdy = a_ready;
            tick();
            if (rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!keep_valid || !ok) begin
            a_valid = 1'b0;
            a_data  = 8'($urandom);
        end
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (frames.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (a_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (a_en !== 1'b0)    begin errors++; $display("FAIL reset_a_enable: got %b expected 0", a_en); end
        checks++; if (a_start !== 1'b0) begin errors++; $display("FAIL reset_a_start: got %b expected 0", a_start); end
        checks++; if (a_ser !== 1'b0)   begin errors++; $display("FAIL reset_a_serial: got %b expected 0", a_ser); end
        checks++; if (a_busy !== 1'b0)  begin errors++; $display("FAIL reset_a_busy: got %b expected 0", a_busy); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_a_ready: got %b expected 1", a_ready); end
        checks++; if (b_en !== 1'b0)    begin errors++; $display("FAIL reset_b_enable: got %b expected 0", b_en); end
        checks++; if (b_busy !== 1'b0)  begin errors++; $display("FAIL reset_b_busy: got %b expected 0", b_busy); end
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL reset_b_ready: got %b expected 1", b_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_cpb3();
        logic [7:0] w;
        bit         seen;
        w = 8'h81;
        b_data  = w;
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        b_data  = 8'($urandom);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (b_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL cpb3_start_timeout: got %b expected 1", seen); end
        for (int off = 0; off < 3 * W; off++) begin
            checks++;
            if (b_en !== ((off % 3) == 0)) begin
                errors++; $display("FAIL cpb3_enable off=%0d: got %b expected %b", off, b_en, (off % 3) == 0);
            end
            checks++;
            if (b_start !== (off == 0)) begin
                errors++; $display("FAIL cpb3_start off=%0d: got %b expected %b", off, b_start, off == 0);
            end
            checks++;
            if (b_ser !== w[7 - off / 3]) begin
                errors++; $display("FAIL cpb3_serial off=%0d: got %b expected %b", off, b_ser, w[7 - off / 3]);
            end
            tick();
        end
        checks++; if (b_en !== 1'b0)  begin errors++; $display("FAIL cpb3_post_enable: got %b expected 0", b_en); end
        checks++; if (b_ser !== 1'b0) begin errors++; $display("FAIL cpb3_post_serial: got %b expected 0", b_ser); end
        repeat (4) tick();
    endtask

    task automatic test_single();
        bit ok;
        clear_logs();
        send_a(8'hA5, 1'b0, ok);
        checks++; if (ok !== 1'b1)      begin errors++; $display("FAIL single_accept: got %b expected 1", ok); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL single_ready_held: got %b expected 0", a_ready); end
        checks++; if (a_busy !== 1'b1)  begin errors++; $display("FAIL single_busy_held: got %b expected 1", a_busy); end
        wait_frames(1, 40, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_frame_timeout: got %0d frames expected 1", frames.size()); end
        model_run();
        if (frames.size() >= 1 && acc_q.size() >= 1) begin
            checks++; if (frames[0].w !== 8'hA5) begin errors++; $display("FAIL single_word: got %h expected a5", frames[0].w); end
            checks++; if (frames[0].st !== m_st[0]) begin errors++; $display("FAIL single_start_cycle: got %0d expected %0d", frames[0].st, m_st[0]); end
            checks++; if (frames[0].last - frames[0].st !== W - 1) begin errors++; $display("FAIL single_length: got %0d expected %0d", frames[0].last - frames[0].st, W - 1); end
            checks++; if (acc_q[0] !== m_acc[0]) begin errors++; $display("FAIL single_accept_cycle: got %0d expected %0d", acc_q[0], m_acc[0]); end
        end
        wait_idle(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_idle: got busy %b expected 0", a_busy); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_logs();
        send_a(8'h3C, 1'b1, ok);
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_first_held: got %b expected 0", a_ready); end
        send_a(8'hC3, 1'b0, ok);
        checks++; if (ok !== 1'b1)      begin errors++; $display("FAIL b2b_second_accept: got %b expected 1", ok); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_midframe: got %b expected 0", a_ready); end
        wait_frames(2, 60, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_frame_timeout: got %0d frames expected 2", frames.size()); end
        model_run();
        if (frames.size() >= 2) begin
            checks++; if (frames[0].w !== 8'h3C) begin errors++; $display("FAIL b2b_word0: got %h expected 3c", frames[0].w); end
            checks++; if (frames[1].w !== 8'hC3) begin errors++; $display("FAIL b2b_word1: got %h expected c3", frames[1].w); end
            checks++; if (frames[1].st - frames[0].last !== 1 + GAP) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", frames[1].st - frames[0].last, 1 + GAP); end
            checks++; if (frames[1].st !== m_st[1]) begin errors++; $display("FAIL b2b_start1_cycle: got %0d expected %0d", frames[1].st, m_st[1]); end
        end
        wait_idle(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_idle: got busy %b expected 0", a_busy); end
    endtask

    task automatic test_random();
        bit ok;
        bit keep;
        int n;
        n = 16;
        clear_logs();
        keep = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!keep) repeat ($urandom_range(0, 10)) tick();
            keep = ($urandom_range(0, 2) == 0) && (i != n - 1);
            send_a(8'($urandom), keep, ok);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rand_accept_timeout word=%0d: got %b expected 1", i, ok); end
        end
        a_valid = 1'b0;
        wait_frames(n, n * 30 + 50, ok);
        checks++; if (frames.size() !== n) begin errors++; $display("FAIL rand_frame_count: got %0d expected %0d", frames.size(), n); end
        model_run();
        for (int i = 0; i < n && i < frames.size() && i < acc_q.size(); i++) begin
            checks++; if (frames[i].w !== m_word[i]) begin errors++; $display("FAIL rand_word idx=%0d: got %h expected %h", i, frames[i].w, m_word[i]); end
            checks++; if (frames[i].st !== m_st[i]) begin errors++; $display("FAIL rand_start idx=%0d: got %0d expected %0d", i, frames[i].st, m_st[i]); end
            checks++; if (acc_q[i] !== m_acc[i]) begin errors++; $display("FAIL rand_accept idx=%0d: got %0d expected %0d", i, acc_q[i], m_acc[i]); end
            checks++; if (frames[i].last - frames[i].st !== W - 1) begin errors++; $display("FAIL rand_length idx=%0d: got %0d expected %0d", i, frames[i].last - frames[i].st, W - 1); end
        end
        wait_idle(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rand_idle: got busy %b expected 0", a_busy); end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        clear_logs();
        send_a(8'hFF, 1'b0, ok);
        send_a(8'h00, 1'b0, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_hold_accept: got %b expected 1", ok); end
        repeat (3) tick();
        checks++; if (a_ser !== 1'b1) begin errors++; $display("FAIL rstmid_bit4_before: got %b expected 1", a_ser); end
        rst_n = 1'b0;
        tick();
        checks++; if (a_en !== 1'b0)    begin errors++; $display("FAIL rstmid_enable: got %b expected 0", a_en); end
        checks++; if (a_ser !== 1'b0)   begin errors++; $display("FAIL rstmid_serial: got %b expected 0", a_ser); end
        checks++; if (a_start !== 1'b0) begin errors++; $display("FAIL rstmid_start: got %b expected 0", a_start); end
        checks++; if (a_busy !== 1'b0)  begin errors++; $display("FAIL rstmid_busy: got %b expected 0", a_busy); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", a_ready); end
        rst_n = 1'b1;
        repeat (20) tick();
        checks++; if (frames.size() !== 0) begin errors++; $display("FAIL rstmid_words_lost: got %0d frames expected 0", frames.size()); end
        checks++; if (a_busy !== 1'b0)     begin errors++; $display("FAIL rstmid_stays_idle: got %b expected 0", a_busy); end
        clear_logs();
        send_a(8'h5A, 1'b0, ok);
        wait_frames(1, 40, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_frame_timeout: got %0d frames expected 1", frames.size()); end
        model_run();
        if (frames.size() >= 1) begin
            checks++; if (frames[0].w !== 8'h5A) begin errors++; $display("FAIL rstmid_word: got %h expected 5a", frames[0].w); end
            checks++; if (frames[0].st !== m_st[0]) begin errors++; $display("FAIL rstmid_start_cycle: got %0d expected %0d", frames[0].st, m_st[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_cpb3();
        test_single();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
